dma_master_burst: RTL and testbench

Parametrised AXI4 DMA master, successor to the current single-mode DMA master: copies qty_i data words from src to dst through an internal FIFO, in bursts of up to MAX_BURST beats. Adds per-side FIXED/INCR addressing, 4 KB boundary splitting, response-error reporting and exact beat counting. Sits on the AXI bus as master, driven by the DMA register/control slave.

---
 rtl/dma_master_burst.sv | 241 ++++++++++++++++++++++++
 tb/tb_dma_master_burst.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_master_burst.sv
// dma_master_burst
//   AXI4 DMA master. Copies qty_i words from a source to a destination
//   through a small internal FIFO. Each burst is up to MAX_BURST beats and
//   never crosses a 4 KB page on an INCR side. Each side is FIXED or INCR.
//   A read or write response error, or an rlast that disagrees with the
//   beat count, sets a sticky error. The burst in flight still completes,
//   and then the transfer stops.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   start_i                  start pulse, accepted only while idle
//   src_addr_i, dst_addr_i   byte addresses (low bits forced to word alignment)
//   qty_i                    transfer length in words
//   mode_i                   [0] source FIXED, [1] destination FIXED
//   busy_o, done_o, err_o    status: busy level, done pulse, sticky error
//   ar*, r*                  AXI read address / read data channels
//   aw*, w*, b*              AXI write address / write data / write response
module dma_master_burst #(
  parameter int         DATA_W     = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MAX_BURST  = 16,
  parameter logic [3:0] DMA_ID     = 4'h2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [31:0]         qty_i,
  input  logic [1:0]          mode_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [3:0]          arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready
);

  localparam int BYTES   = DATA_W / 8;
  localparam int SIZE_LG = $clog2(BYTES);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_AR, S_AW, S_XFER, S_RESP, S_DONE
  } state_t;

  // Unsigned minimum, used to clamp the burst length.
  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // Beats left before the 4 KB page ends. A FIXED side never advances, so it
  // places no limit on the burst length.
  function automatic logic [31:0] side_room(input logic [31:0] addr, input logic fixed_mode);
    logic [12:0] left;
    left = 13'd4096 - {1'b0, addr[11:0]};
    return fixed_mode ? 32'hFFFF_FFFF : 32'(left >> SIZE_LG);
  endfunction

  state_t                 state_q, state_d;
  logic [31:0]            src_q, src_d, dst_q, dst_d, rem_q, rem_d;
  logic [1:0]             mode_q, mode_d;
  logic [7:0]             len_q, len_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic                   err_q, err_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];

  logic        fifo_full, fifo_empty, push, pop;
  logic [31:0] burst_beats, burst_len_w, burst_bytes;

  assign fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // All handshake outputs decode registered state or FIFO occupancy only,
  // so no ready input reaches a valid output combinationally.
  assign arvalid = (state_q == S_AR);
  assign awvalid = (state_q == S_AW);
  assign rready  = (state_q == S_XFER) && !fifo_full;
  assign wvalid  = (state_q == S_XFER) && !fifo_empty;
  assign wlast   = wvalid && (wcnt_q == len_q);
  assign bready  = (state_q == S_RESP);
  assign busy_o  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o  = (state_q == S_DONE);
  assign err_o   = err_q;

  assign push = rvalid && rready;
  assign pop  = wvalid && wready;

  assign arid    = DMA_ID;
  assign awid    = DMA_ID;
  assign araddr  = src_q;
  assign awaddr  = dst_q;
  assign arlen   = len_q;
  assign awlen   = len_q;
  assign arsize  = 3'(SIZE_LG);
  assign awsize  = 3'(SIZE_LG);
  assign arburst = mode_q[0] ? 2'b00 : 2'b01;
  assign awburst = mode_q[1] ? 2'b00 : 2'b01;
  assign wstrb   = '1;
  // An empty FIFO drives zero data rather than stale storage contents.
  assign wdata   = fifo_empty ? '0 : mem_q[rd_ptr_q];

  assign burst_beats = min_u32(min_u32(rem_q, 32'(MAX_BURST)),
                               min_u32(side_room(src_q, mode_q[0]),
                                       side_room(dst_q, mode_q[1])));
  assign burst_len_w = 32'(len_q) + 32'd1;
  assign burst_bytes = burst_len_w << SIZE_LG;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    len_d    = len_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    // Read side: push into the FIFO. Check rlast against our own beat count.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rcnt_d   = rcnt_q + 8'd1;
      if ((rlast != (rcnt_q == len_q)) || (rresp != 2'b00)) err_d = 1'b1;
    end

    // Write side: pop from the FIFO.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      wcnt_d   = wcnt_q + 8'd1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & ~32'(BYTES - 1);
          dst_d   = dst_addr_i & ~32'(BYTES - 1);
          rem_d   = qty_i;
          mode_d  = mode_i;
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (rem_q == 32'd0) begin
          state_d = S_DONE;
        end else begin
          len_d   = 8'(burst_beats - 32'd1);
          rcnt_d  = '0;
          wcnt_d  = '0;
          state_d = S_AR;
        end
      end
      S_AR:   if (arready) state_d = S_AW;
      S_AW:   if (awready) state_d = S_XFER;
      S_XFER: if (pop && wlast) state_d = S_RESP;
      S_RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          rem_d = rem_q - burst_len_w;
          if (!mode_q[0]) src_d = src_q + burst_bytes;
          if (!mode_q[1]) dst_d = dst_q + burst_bytes;
          // After an error, stop once this burst is acknowledged.
          state_d = ((rem_d == 32'd0) || err_d) ? S_DONE : S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      len_q    <= '0;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      rcnt_q   <= rcnt_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage holds data only. The pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rdata;
  end

endmodule

// File: tb/tb_dma_master_burst.sv
module tb_dma_master_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0, dst_addr_i = '0, qty_i = '0;
  logic [1:0]  mode_i = '0;
  logic        busy_o, done_o, err_o;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid, rready, wlast, wvalid, bready;
  logic        arready = 1'b0, awready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic        wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0, wdata;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  dma_master_burst dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .qty_i(qty_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  // Slave model: logs, pending bursts and configuration.
  logic [31:0] ar_addr_l[$], aw_addr_l[$], w_data_l[$], w_addr_l[$];
  int          ar_len_l[$], ar_burst_l[$], aw_len_l[$], aw_burst_l[$];
  logic        w_last_l[$];
  logic [31:0] rq_addr[$], wq_addr[$];
  int          rq_len[$], rq_burst[$], wq_len[$], wq_burst[$];
  logic [31:0] rd_addr = '0;
  int          rd_len = 0, rd_burst = 0, rd_idx = 0;
  logic        rd_active = 1'b0;
  int          r_seq = 0, r_hs = 0, r_hs_seen = 0;
  int          w_idx = 0, pending_b = 0, b_count = 0, b_hs = 0, b_hs_seen = 0;
  logic        stall = 1'b0;
  int          b_err_at = -1;
  logic [1:0]  rresp_val = 2'b00;

  int checks = 0, errors = 0;
  int ar0, aw0, w0, seq0, b0;
  int          exp_len [3];
  logic [31:0] exp_sa [3], exp_da [3];

  always @(posedge clk) begin
    if (!rst) begin
      rq_addr.delete(); rq_len.delete(); rq_burst.delete();
      wq_addr.delete(); wq_len.delete(); wq_burst.delete();
      rd_active = 1'b0; rd_idx = 0; w_idx = 0; pending_b = 0;
    end else begin
      if (arvalid && arready) begin
        ar_addr_l.push_back(araddr); ar_len_l.push_back(int'(arlen)); ar_burst_l.push_back(int'(arburst));
        rq_addr.push_back(araddr); rq_len.push_back(int'(arlen)); rq_burst.push_back(int'(arburst));
      end
      if (awvalid && awready) begin
        aw_addr_l.push_back(awaddr); aw_len_l.push_back(int'(awlen)); aw_burst_l.push_back(int'(awburst));
        wq_addr.push_back(awaddr); wq_len.push_back(int'(awlen)); wq_burst.push_back(int'(awburst));
      end
      if (rvalid && rready) begin
        r_seq++; r_hs++; rd_idx++;
        if (rd_idx > rd_len) rd_active = 1'b0;
      end
      if (!rd_active && rq_addr.size() > 0) begin
        rd_addr = rq_addr.pop_front(); rd_len = rq_len.pop_front(); rd_burst = rq_burst.pop_front();
        rd_idx = 0; rd_active = 1'b1;
      end
      if (wvalid && wready) begin
        w_data_l.push_back(wdata); w_last_l.push_back(wlast);
        if (wq_addr.size() > 0) begin
          w_addr_l.push_back(wq_burst[0] == 1 ? wq_addr[0] + 32'(w_idx * 4) : wq_addr[0]);
          if (w_idx == wq_len[0]) begin
            void'(wq_addr.pop_front()); void'(wq_len.pop_front()); void'(wq_burst.pop_front());
            w_idx = 0; pending_b++;
          end else begin
            w_idx++;
          end
        end else begin
          w_addr_l.push_back(32'hDEAD_BEEF);
        end
      end
      if (bvalid && bready) begin
        pending_b--; b_count++; b_hs++;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ba;
    if (!rst) begin
      arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
      bvalid = 0; bresp = 0; r_hs_seen = r_hs; b_hs_seen = b_hs;
    end else begin
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (!rvalid || r_hs != r_hs_seen) begin
        r_hs_seen = r_hs;
        if (rd_active && (!stall || $urandom_range(0, 2) != 0)) begin
          ba = (rd_burst == 1) ? rd_addr + 32'(rd_idx * 4) : rd_addr;
          rvalid = 1'b1; rdata = {r_seq[7:0], 8'hA5, ba[15:0]};
          rlast = (rd_idx == rd_len); rresp = rresp_val;
        end else begin
          rvalid = 1'b0; rlast = 1'b0;
        end
      end
      if (!bvalid || b_hs != b_hs_seen) begin
        b_hs_seen = b_hs;
        if (pending_b > 0) begin
          bvalid = 1'b1; bresp = (b_count == b_err_at) ? 2'b10 : 2'b00;
        end else begin
          bvalid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    ar0 = ar_addr_l.size(); aw0 = aw_addr_l.size(); w0 = w_data_l.size();
    seq0 = r_seq; b0 = b_count;
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] q, input logic [1:0] m);
    src_addr_i = s; dst_addr_i = d; qty_i = q; mode_i = m; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic exp_err);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      tick(1); n++;
    end
    chk({tag, "_done"}, done_o, 1'b1);
    chk({tag, "_busy_at_done"}, busy_o, 1'b0);
    chk({tag, "_err"}, err_o, exp_err);
    tick(1);
    chk({tag, "_done_pulse"}, done_o, 1'b0);
  endtask

  task automatic check_bursts(input string tag, input int nb, input int burst);
    int pos = 0;
    chk({tag, "_ar_cnt"}, ar_addr_l.size() - ar0, nb);
    chk({tag, "_aw_cnt"}, aw_addr_l.size() - aw0, nb);
    for (int i = 0; i < nb; i++) begin
      if (ar0 + i < ar_addr_l.size()) begin
        chk($sformatf("%s_araddr%0d", tag, i), ar_addr_l[ar0+i], exp_sa[i]);
        chk($sformatf("%s_arlen%0d", tag, i), ar_len_l[ar0+i], exp_len[i] - 1);
        chk($sformatf("%s_arburst%0d", tag, i), ar_burst_l[ar0+i], burst);
      end
      if (aw0 + i < aw_addr_l.size()) begin
        chk($sformatf("%s_awaddr%0d", tag, i), aw_addr_l[aw0+i], exp_da[i]);
        chk($sformatf("%s_awlen%0d", tag, i), aw_len_l[aw0+i], exp_len[i] - 1);
        chk($sformatf("%s_awburst%0d", tag, i), aw_burst_l[aw0+i], burst);
      end
      for (int j = 0; j < exp_len[i]; j++) begin
        if (w0 + pos < w_last_l.size())
          chk($sformatf("%s_wlast%0d", tag, pos), w_last_l[w0+pos], j == exp_len[i] - 1);
        pos++;
      end
    end
  endtask

  task automatic check_data(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [1:0] m);
    logic [31:0] sa, da;
    logic [7:0]  sq;
    chk({tag, "_wcnt"}, w_data_l.size() - w0, n);
    for (int k = 0; k < n; k++) begin
      sa = m[0] ? s : s + 32'(4 * k);
      da = m[1] ? d : d + 32'(4 * k);
      sq = 8'(seq0 + k);
      if (w0 + k < w_data_l.size()) begin
        chk($sformatf("%s_wdata%0d", tag, k), w_data_l[w0+k], {sq, 8'hA5, sa[15:0]});
        chk($sformatf("%s_waddr%0d", tag, k), w_addr_l[w0+k], da);
      end
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_flags", {arvalid, awvalid, rready, wvalid, bready, busy_o, done_o, err_o}, 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    chk("rst_len_data", {arlen, awlen, wdata}, 0);
    chk("const_fields", {arid, awid, arsize, awsize, wstrb}, {4'h2, 4'h2, 3'd2, 3'd2, 4'hF});
    rst = 1'b1;
    tick(2);

    // Single 5-beat INCR burst
    mark();
    start_xfer(32'h0000_1000, 32'h2000_0000, 5, 2'b00);
    chk("t1_busy", busy_o, 1'b1);
    wait_done("t1", 200, 1'b0);
    exp_len = '{5, 0, 0}; exp_sa[0] = 32'h0000_1000; exp_da[0] = 32'h2000_0000;
    check_bursts("t1", 1, 1);
    check_data("t1", 32'h0000_1000, 32'h2000_0000, 5, 2'b00);

    // 40 words -> 16/16/8; a start while busy is ignored
    mark();
    start_xfer(32'h0000_1000, 32'h2000_0000, 40, 2'b00);
    tick(3);
    qty_i = 1; start_i = 1'b1; tick(1); start_i = 1'b0;
    wait_done("t2", 1000, 1'b0);
    chk("t2_b_before_done", b_count - b0, 3);
    exp_len = '{16, 16, 8};
    exp_sa = '{32'h0000_1000, 32'h0000_1040, 32'h0000_1080};
    exp_da = '{32'h2000_0000, 32'h2000_0040, 32'h2000_0080};
    check_bursts("t2", 3, 1);
    check_data("t2", 32'h0000_1000, 32'h2000_0000, 40, 2'b00);

    // 4 KB boundary split on the source side
    mark();
    start_xfer(32'h0000_0FF8, 32'h2000_0000, 8, 2'b00);
    wait_done("t3", 500, 1'b0);
    exp_len = '{2, 6, 0};
    exp_sa = '{32'h0000_0FF8, 32'h0000_1000, 32'h0};
    exp_da = '{32'h2000_0000, 32'h2000_0008, 32'h0};
    check_bursts("t3", 2, 1);
    check_data("t3", 32'h0000_0FF8, 32'h2000_0000, 8, 2'b00);

    // FIXED both sides with random stalls
    stall = 1'b1;
    mark();
    start_xfer(32'h0000_3000, 32'h0000_4000, 3, 2'b11);
    wait_done("t4", 2000, 1'b0);
    exp_len = '{3, 0, 0}; exp_sa[0] = 32'h0000_3000; exp_da[0] = 32'h0000_4000;
    check_bursts("t4", 1, 0);
    check_data("t4", 32'h0000_3000, 32'h0000_4000, 3, 2'b11);

    // FIXED, 12 beats, slow write side fills the FIFO; unaligned source address
    mark();
    start_xfer(32'h0000_3002, 32'h0000_4000, 12, 2'b11);
    wait_done("t4b", 3000, 1'b0);
    exp_len = '{12, 0, 0}; exp_sa[0] = 32'h0000_3000; exp_da[0] = 32'h0000_4000;
    check_bursts("t4b", 1, 0);
    check_data("t4b", 32'h0000_3000, 32'h0000_4000, 12, 2'b11);
    stall = 1'b0;

    // Write response error on the first of three bursts
    mark();
    b_err_at = b_count;
    start_xfer(32'h0000_1000, 32'h2000_0000, 40, 2'b00);
    wait_done("t5", 1000, 1'b1);
    b_err_at = -1;
    chk("t5_ar_cnt", ar_addr_l.size() - ar0, 1);
    chk("t5_wcnt", w_data_l.size() - w0, 16);
    tick(3);
    chk("t5_err_sticky", err_o, 1'b1);

    // qty 0: done on the next-but-one cycle, error cleared, no bus traffic
    mark();
    start_xfer(32'h0000_1000, 32'h2000_0000, 0, 2'b00);
    chk("t5z_setup", {busy_o, done_o, err_o, arvalid, awvalid}, 5'b10000);
    tick(1);
    chk("t5z_done", {busy_o, done_o, arvalid, awvalid}, 4'b0100);
    tick(1);
    chk("t5z_done_pulse", done_o, 1'b0);
    chk("t5z_no_ar", ar_addr_l.size() - ar0, 0);

    // Read response error: burst completes, error reported
    mark();
    rresp_val = 2'b10;
    start_xfer(32'h0000_1000, 32'h2000_0000, 5, 2'b00);
    wait_done("t5r", 200, 1'b1);
    rresp_val = 2'b00;
    chk("t5r_wcnt", w_data_l.size() - w0, 5);

    // Reset in the middle of a data phase, then a clean transfer
    stall = 1'b1;
    start_xfer(32'h0000_1000, 32'h2000_0000, 40, 2'b00);
    begin
      int n = 0;
      while (rready !== 1'b1 && n < 200) begin
        tick(1); n++;
      end
      chk("t6_reached_xfer", rready, 1'b1);
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("t6_rst_flags", {arvalid, awvalid, rready, wvalid, bready, busy_o, done_o, err_o}, 0);
    tick(1);
    rst = 1'b1;
    stall = 1'b0;
    tick(2);
    mark();
    start_xfer(32'h0000_5000, 32'h0000_6000, 5, 2'b00);
    wait_done("t6", 200, 1'b0);
    exp_len = '{5, 0, 0}; exp_sa[0] = 32'h0000_5000; exp_da[0] = 32'h0000_6000;
    check_bursts("t6", 1, 1);
    check_data("t6", 32'h0000_5000, 32'h0000_6000, 5, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
